ocp_slave_fsm: RTL

//  OCP 2.2 slave-side controller. It pairs with ocp_master_fsm as the responder on the same OCP link.
//  - Accepts WR/RD requests, including multi-request precise bursts (one request per beat, MReqLast on the final beat).
//  - Forwards each accepted beat to a simple local memory-style backend.
//  - Returns in-order SResp/SData/SRespLast through a response-tag FIFO.

---
 rtl/ocp_slave_fsm.sv | 118 +++++++++++
 1 files changed

// File: rtl/ocp_slave_fsm.sv
// OCP 2.2 slave controller: accepts WR/RD beats, drives a memory-style backend, returns in-order responses.
// Define OCP_SLAVE_WRESP_EN to make writes non-posted (DVA response per accepted WR).
module ocp_slave_fsm #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 8,
    parameter int OUTSTANDING = 4
) (
    input  logic                  Clk,
    input  logic                  MReset_n,
    input  logic                  EnableClk,
    input  logic [2:0]            MCmd,
    input  logic [ADDR_WIDTH-1:0] MAddr,
    input  logic [DATA_WIDTH-1:0] MData,
    input  logic [9:0]            MBurstLength,
    input  logic                  MReqLast,
    output logic                  SCmdAccept,
    output logic [1:0]            SResp,
    output logic [DATA_WIDTH-1:0] SData,
    output logic                  SRespLast,
    output logic                  burst_err,
    input  logic                  bus_ready,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_wr_en,
    output logic [DATA_WIDTH-1:0] bus_wr_data,
    output logic                  bus_rd_en,
    input  logic                  bus_rd_valid,
    output logic                  bus_rd_ready,
    input  logic [DATA_WIDTH-1:0] bus_rd_data
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [1:0] RESP_NULL = 2'b00, RESP_DVA = 2'b01, RESP_ERR = 2'b11;

    typedef enum logic [1:0] {K_RD = 2'd0, K_WR = 2'd1, K_ERR = 2'd2} kind_t;
    typedef struct packed {
        kind_t kind;
        logic  last;
    } ent_t;

    ent_t            fifo [OUTSTANDING];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [9:0]      beat_cnt;

    logic            is_idle, is_wr, is_rd, unsup, full, empty, is_last, push, pop;
    logic [9:0]      len;
    ent_t            head, push_ent;

    assign is_idle = (MCmd == 3'b000);
    assign is_wr   = (MCmd == 3'b001);
    assign is_rd   = (MCmd == 3'b010);
    assign unsup   = !(is_idle | is_wr | is_rd);
    assign full    = (count == (PW+1)'(OUTSTANDING));
    assign empty   = (count == '0);
    assign len     = (MBurstLength == 10'd0) ? 10'd1 : MBurstLength;
    assign is_last = (beat_cnt == len - 10'd1);
    assign head    = fifo[rd_ptr];

    // Unsupported codes are answered locally with ERR, so they need no backend readiness.
    assign SCmdAccept   = EnableClk & !full & !is_idle & (bus_ready | unsup);
    assign bus_wr_en    = SCmdAccept & is_wr;
    assign bus_rd_en    = SCmdAccept & is_rd;
    assign bus_addr     = MAddr;
    assign bus_wr_data  = MData;
    assign bus_rd_ready = EnableClk & !empty & (head.kind == K_RD);
    assign pop          = EnableClk & !empty & ((head.kind != K_RD) | bus_rd_valid);

    always_comb begin
        push     = 1'b0;
        push_ent = '{kind: K_ERR, last: 1'b1};
        if (SCmdAccept) begin
            if (unsup) begin
                push = 1'b1;
            end else if (is_rd) begin
                push     = 1'b1;
                push_ent = '{kind: K_RD, last: is_last};
            end
`ifdef OCP_SLAVE_WRESP_EN
            else if (is_wr) begin
                push     = 1'b1;
                push_ent = '{kind: K_WR, last: is_last};
            end
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (EnableClk && push) fifo[wr_ptr] <= push_ent;
    end

    always_ff @(posedge Clk or negedge MReset_n) begin
        if (!MReset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_cnt  <= '0;
            SResp     <= RESP_NULL;
            SData     <= '0;
            SRespLast <= 1'b0;
            burst_err <= 1'b0;
        end else if (EnableClk) begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (SCmdAccept && !unsup)
                beat_cnt <= (is_last | MReqLast) ? 10'd0 : beat_cnt + 10'd1;
            burst_err <= SCmdAccept & (MReqLast != is_last);
            if (pop) begin
                SResp     <= (head.kind == K_ERR) ? RESP_ERR : RESP_DVA;
                SData     <= (head.kind == K_RD) ? bus_rd_data : '0;
                SRespLast <= head.last;
            end else begin
                SResp     <= RESP_NULL;
                SData     <= '0;
                SRespLast <= 1'b0;
            end
        end
    end
endmodule
